// File: rtl/symbol_generator.sv
// symbol_generator: divides Clk100M by symGenMax into a symbol tick and queues non-repeating
// LFSR symbols for the match logic. Overflow sets sticky gameOver. Optional macro: SYMGEN_STATS_EN.
module symbol_generator #(
    parameter int          SYM_W = 2,
    parameter int          DEPTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic [31:0]      symGenMax,
    input  logic             newLevel,
    input  logic             symConsume,
    output logic             symValid,
    output logic [SYM_W-1:0] symOut,
    output logic [4:0]       symCount,
    output logic             gameOver
`ifdef SYMGEN_STATS_EN
    ,
    output logic [15:0]      symTotal
`endif
);
    localparam int          PTR_W     = $clog2(DEPTH);
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

    logic [31:0]      divCnt;
    logic [31:0]      period;
    logic             tick;
    logic [15:0]      lfsr;
    logic             lfsrFb;
    logic [SYM_W-1:0] cand;
    logic [SYM_W-1:0] pushSym;
    logic [SYM_W-1:0] lastSym;
    logic             hasLast;
    logic [SYM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             full;
    logic             doPush;
    logic             doPop;
    logic             overflow;

    // A count at or past the end of a freshly shortened period still ticks on the next cycle.
    assign period = (symGenMax == 32'd0) ? 32'd1 : symGenMax;
    assign tick   = !newLevel && (divCnt >= period - 32'd1);

    // Fibonacci taps 16,14,13,11 (1-based from the LSB); feedback enters bit 0.
    assign lfsrFb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cand    = lfsr[SYM_W-1:0];
    assign pushSym = (hasLast && (cand == lastSym)) ? cand + SYM_W'(1) : cand;

    // Handshake: symValid/symOut present the head; a cycle with symValid && symConsume pops it,
    // symConsume while !symValid is ignored.
    assign full     = (symCount == DEPTH_CNT);
    assign doPop    = symConsume && (symCount != 5'd0);
    assign doPush   = tick && !gameOver && (!full || doPop);
    assign overflow = tick && !gameOver && full && !doPop;
    assign symValid = (symCount != 5'd0);
    assign symOut   = symValid ? mem[rdPtr] : '0;

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            divCnt <= 32'd0;
            lfsr   <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[14:0], lfsrFb};
            if (newLevel || tick) begin
                divCnt <= 32'd0;
            end else begin
                divCnt <= divCnt + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            symCount <= 5'd0;
            gameOver <= 1'b0;
            hasLast  <= 1'b0;
            lastSym  <= '0;
        end else begin
            if (doPush) begin
                wrPtr   <= wrPtr + PTR_W'(1);
                lastSym <= pushSym;
                hasLast <= 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                symCount <= symCount + 5'd1;
            end else if (doPop && !doPush) begin
                symCount <= symCount - 5'd1;
            end
            if (overflow) begin
                gameOver <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while symCount covers them.
    always_ff @(posedge Clk100M) begin
        if (Rst_n && doPush) begin
            mem[wrPtr] <= pushSym;
        end
    end

`ifdef SYMGEN_STATS_EN
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            symTotal <= 16'd0;
        end else if (doPush && (symTotal != 16'hFFFF)) begin
            symTotal <= symTotal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_symbol_generator.sv
// Directed bench for symbol_generator: hand-scheduled ticks/pops, with an expected-symbol queue
// fed by an independent LFSR reference.
module tb_symbol_generator;
    localparam int          SYM_W = 2;
    localparam int          DEPTH = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             Clk100M = 1'b0;
    logic             Rst_n = 1'b1;
    logic [31:0]      symGenMax = 32'd0;
    logic             newLevel = 1'b0;
    logic             symConsume = 1'b0;
    logic             symValid;
    logic [SYM_W-1:0] symOut;
    logic [4:0]       symCount;
    logic             gameOver;
`ifdef SYMGEN_STATS_EN
    logic [15:0]      symTotal;
`endif

    int               n_checks = 0;
    int               n_errors = 0;
    logic [SYM_W-1:0] exp_q[$];
    logic [15:0]      m_lfsr;
    logic             m_has_last;
    logic [SYM_W-1:0] m_last;
    logic             exp_go;
    int               exp_total;

    symbol_generator #(.SYM_W(SYM_W), .DEPTH(DEPTH), .SEED(SEED)) dut (
        .Clk100M   (Clk100M),
        .Rst_n     (Rst_n),
        .symGenMax (symGenMax),
        .newLevel  (newLevel),
        .symConsume(symConsume),
        .symValid  (symValid),
        .symOut    (symOut),
        .symCount  (symCount),
        .gameOver  (gameOver)
`ifdef SYMGEN_STATS_EN
        ,
        .symTotal  (symTotal)
`endif
    );

    // Clock / reference LFSR
    always #5 Clk100M = ~Clk100M;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    always @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(symCount), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(symValid), 32'(exp_q.size() != 0));
        check({tag, "_sym"}, 32'(symOut), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        check({tag, "_go"}, 32'(gameOver), 32'(exp_go));
`ifdef SYMGEN_STATS_EN
        check({tag, "_total"}, 32'(symTotal), 32'(exp_total));
`endif
    endtask

    // Driver tasks
    task automatic do_reset(input logic [31:0] gen_max);
        Rst_n      = 1'b0;
        newLevel   = 1'b0;
        symConsume = 1'b0;
        symGenMax  = gen_max;
        exp_q.delete();
        m_has_last = 1'b0;
        m_last     = '0;
        exp_go     = 1'b0;
        exp_total  = 0;
        #2;
        check_state("reset_async");
        @(posedge Clk100M); #1;
        check_state("reset");
        Rst_n = 1'b1;
    endtask

    // One clock: 'push' says a tick is due on this edge, 'pop' drives symConsume.
    task automatic run_cycle(input bit push, input bit pop);
        logic [SYM_W-1:0] sym;
        symConsume = pop;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (push && !exp_go) begin
            if (exp_q.size() < DEPTH) begin
                sym = m_lfsr[SYM_W-1:0];
                if (m_has_last && sym == m_last) sym = SYM_W'(sym + 1);
                exp_q.push_back(sym);
                m_last     = sym;
                m_has_last = 1'b1;
                if (exp_total < 65535) exp_total++;
            end else begin
                exp_go = 1'b1;
            end
        end
        @(posedge Clk100M); #1;
        symConsume = 1'b0;
    endtask

    logic [SYM_W-1:0] prev;

    initial begin
        #2;
        // T1: period 4, pushes on cycles 3, 7, 11
        do_reset(32'd4);
        for (int c = 0; c < 12; c++) begin
            run_cycle((c % 4) == 3, 1'b0);
            check_state($sformatf("t1_c%0d", c));
        end
        check("t1_final_count", 32'(symCount), 32'd3);

        // T2: period 0 -> tick every cycle; fill, overflow, then drain with gameOver held
        do_reset(32'd0);
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b1, 1'b0);
            check_state($sformatf("t2_fill%0d", c));
        end
        check("t2_full_go", 32'(gameOver), 32'd0);
        run_cycle(1'b1, 1'b0);
        check_state("t2_overflow");
        check("t2_go_set", 32'(gameOver), 32'd1);
        check("t2_count_kept", 32'(symCount), 32'd8);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b1, 1'b0);
            check_state($sformatf("t2_stuck%0d", c));
        end
        for (int c = 0; c < 8; c++) begin
            prev = symOut;
            run_cycle(1'b1, 1'b1);
            check_state($sformatf("t2_drain%0d", c));
            if (exp_q.size() != 0) check($sformatf("t2_norepeat%0d", c), 32'(symOut != prev), 32'd1);
        end
        check("t2_go_sticky", 32'(gameOver), 32'd1);

        // T3: full queue, tick and consume together keeps count at 8 without gameOver
        do_reset(32'd0);
        for (int c = 0; c < 8; c++) run_cycle(1'b1, 1'b0);
        check_state("t3_full");
        for (int c = 0; c < 4; c++) begin
            run_cycle(1'b1, 1'b1);
            check_state($sformatf("t3_swap%0d", c));
            check($sformatf("t3_count%0d", c), 32'(symCount), 32'd8);
            check($sformatf("t3_go%0d", c), 32'(gameOver), 32'd0);
        end

        // T4: consume on an empty queue is ignored
        do_reset(32'd1000);
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, 1'b1);
            check_state($sformatf("t4_c%0d", c));
            check($sformatf("t4_valid%0d", c), 32'(symValid), 32'd0);
        end

        // T5: newLevel at divCnt=50 restarts the period; next tick 100 cycles later
        do_reset(32'd100);
        for (int c = 0; c < 50; c++) run_cycle(1'b0, 1'b0);
        newLevel = 1'b1;
        run_cycle(1'b0, 1'b0);
        newLevel = 1'b0;
        check_state("t5_pulse");
        for (int k = 1; k <= 100; k++) begin
            run_cycle(k == 100, 1'b0);
            check_state($sformatf("t5_k%0d", k));
        end
        check("t5_tick_count", 32'(symCount), 32'd1);

        // Period shrinks below the running count: tick on the very next cycle
        for (int c = 0; c < 20; c++) run_cycle(1'b0, 1'b0);
        symGenMax = 32'd5;
        run_cycle(1'b1, 1'b0);
        check_state("t5_shrink");
        for (int j = 1; j <= 5; j++) begin
            run_cycle(j == 5, 1'b0);
            check_state($sformatf("t5_p5_%0d", j));
        end
        check("t5_final_count", 32'(symCount), 32'd3);

        // Reset in the middle of traffic clears everything
        do_reset(32'd0);
        check("t6_reset_count", 32'(symCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
